// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and 7-segment constants for the switch adder and
//               its scanned hex display.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   // Adder control FSM states
   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by nibble value
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Nibble to active-low segment pattern
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return HEX_SEG[nibble];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_adder_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_adder_scan_if
// Description : Switch/button inputs and LED/7-segment outputs of the switch
//               adder, bundled for connection between board pins and the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_adder_scan_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              mode;
   logic              calc;
   logic [WIDTH-1:0]  sum;
   logic              cout;
   logic              ovf;
   logic              valid;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;

   // Board side: drives switches/button, observes LEDs and display
   modport master (
      output a, b, mode, calc,
      input  sum, cout, ovf, valid, seg, an
   );

   // Core side
   modport slave (
      input  a, b, mode, calc,
      output sum, cout, ovf, valid, seg, an
   );
endinterface
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decoder
// Description : Combinational nibble to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  wire logic [3:0] nibble,
   output logic      [6:0] seg
);

   // Table lookup through the shared package function
   always_comb begin
      seg = hex_to_seg(nibble);
   end

endmodule
`default_nettype wire

// File: rtl/seg7_adder_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_adder_scan
// Description : Button-triggered WIDTH-bit add/subtract of switch operands,
//               with carry/overflow LEDs and a scanned common-anode hex
//               display of {cout,sum}.
//               Optional macro SEG7_ADDER_BLINK_OVF_EN blinks the display
//               while the registered result overflowed.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_adder_scan
   import seg7_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DIGITS    = 3,
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   seg7_adder_scan_if.slave  bus
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DISP_W = 4 * DIGITS;

   // ------------------------------------------------------------------------
   // Button conditioning: two-flop synchroniser plus edge-detect flop
   // ------------------------------------------------------------------------
   logic calc_s1;
   logic calc_s2;
   logic calc_s3;
   logic calc_pulse;

   // Bring the asynchronous button into the clock domain and delay once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         calc_s1 <= 1'b0;
         calc_s2 <= 1'b0;
         calc_s3 <= 1'b0;
      end else begin
         calc_s1 <= bus.calc;
         calc_s2 <= calc_s1;
         calc_s3 <= calc_s2;
      end
   end

   // One pulse per press, however long the button is held
   assign calc_pulse = calc_s2 & ~calc_s3;

   // ------------------------------------------------------------------------
   // Arithmetic FSM
   // ------------------------------------------------------------------------
   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;      // already inverted for subtract
   logic             op_cin;    // 1 for subtract (two's-complement +1)
   logic [WIDTH:0]   result;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;
   logic             valid_r;

   assign result = {1'b0, op_a} + {1'b0, op_b} + (WIDTH+1)'(op_cin);

   // Capture operands on a press, then register the result one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_a    <= '0;
         op_b    <= '0;
         op_cin  <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (calc_pulse) begin
                  op_a   <= bus.a;
                  op_b   <= bus.mode ? ~bus.b : bus.b;
                  op_cin <= bus.mode;
                  state  <= CALC;
               end
            end
            CALC: begin
               sum_r   <= result[WIDTH-1:0];
               cout_r  <= result[WIDTH];
               ovf_r   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                          (result[WIDTH-1] != op_a[WIDTH-1]);
               valid_r <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sum   = sum_r;
   assign bus.cout  = cout_r;
   assign bus.ovf   = ovf_r;
   assign bus.valid = valid_r;

   // ------------------------------------------------------------------------
   // Optional overflow blink
   // ------------------------------------------------------------------------
   logic blank;

`ifdef SEG7_ADDER_BLINK_OVF_EN
   localparam int BLINK_W = $clog2(BLINK_DIV);
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   // Free-running half-period counter, restarted whenever a result lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (state == CALC) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   assign blank = ovf_r & blink_phase;
`else
   logic unused_blink_cfg;
   assign unused_blink_cfg = ^BLINK_DIV;
   assign blank = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Display scan
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_next;
   logic              scan_tc;
   logic [DISP_W-1:0] disp_val;
   logic [3:0]        nibble;
   logic [6:0]        seg_dec;
   logic [DIGITS-1:0] an_next;
   logic [6:0]        seg_r;
   logic [DIGITS-1:0] an_r;

   assign scan_tc  = (scan_cnt == CNT_W'(SCAN_DIV - 1));
   assign disp_val = DISP_W'({cout_r, sum_r});

   // Digit index that will be current after this edge, so an/seg move with it
   always_comb begin
      idx_next = idx;
      if (scan_tc) begin
         idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
   end

   // Select the nibble and the active-low anode for the upcoming digit
   always_comb begin
      nibble  = 4'h0;
      an_next = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_next == IDX_W'(i)) begin
            nibble     = disp_val[i*4 +: 4];
            an_next[i] = 1'b0;
         end
      end
   end

   seg7_hex_decoder u_hex_decoder (
      .nibble (nibble),
      .seg    (seg_dec)
   );

   // Scan timing plus registered segment/anode pair (changes on one edge)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
         seg_r    <= hex_to_seg(4'h0);
         an_r     <= ~DIGITS'(1);
      end else begin
         scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
         idx      <= idx_next;
         seg_r    <= seg_dec;
         an_r     <= blank ? '1 : an_next;
      end
   end

   assign bus.seg = seg_r;
   assign bus.an  = an_r;

endmodule
`default_nettype wire

// File: tb/tb_seg7_adder_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_adder_scan
// Description : Directed self-checking bench for seg7_adder_scan
//               (WIDTH=8, DIGITS=3, SCAN_DIV=4, BLINK_DIV=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_adder_scan;

   localparam int WIDTH     = 8;
   localparam int DIGITS    = 3;
   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 8;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_fail;

   seg7_adder_scan_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   seg7_adder_scan #(
      .WIDTH     (WIDTH),
      .DIGITS    (DIGITS),
      .SCAN_DIV  (SCAN_DIV),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Active-low hex patterns, written out independently of the design
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   // One-cycle press; returns at the negedge after the 4th active edge
   task automatic press(input logic [7:0] a, input logic [7:0] b, input logic m);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.mode = m; bus.calc = 1'b1;
      @(negedge clk);
      bus.calc = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_result(input string tag, input logic [7:0] s, input logic c, input logic o);
      check({tag, ".sum"},   32'(bus.sum),   32'(s));
      check({tag, ".cout"},  32'(bus.cout),  32'(c));
      check({tag, ".ovf"},   32'(bus.ovf),   32'(o));
      check({tag, ".valid"}, 32'(bus.valid), 32'd1);
   endtask

   // Walk one full scan and check each enabled digit's segments
   task automatic check_digits(input string tag, input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
      logic [3:0] n;
      repeat (2) @(negedge clk);
      for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
         case (bus.an)
            3'b110:  n = d0;
            3'b101:  n = d1;
            3'b011:  n = d2;
            default: n = 4'hx;
         endcase
         check({tag, ".seg"}, 32'(bus.seg), 32'(seg_of(n)));
         @(negedge clk);
      end
   endtask

   initial begin
      n_vec    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.a    = '0;
      bus.b    = '0;
      bus.mode = 1'b0;
      bus.calc = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst.sum",   32'(bus.sum),   32'h00);
      check("rst.cout",  32'(bus.cout),  32'd0);
      check("rst.ovf",   32'(bus.ovf),   32'd0);
      check("rst.valid", 32'(bus.valid), 32'd0);
      check("rst.an",    32'(bus.an),    32'b110);
      check("rst.seg",   32'(bus.seg),   32'b1000000);

      // Scan order and dwell: 110 x4, 101 x4, 011 x4, 110 x4
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         case ((k / 4) % 3)
            0:       check("scan.an", 32'(bus.an), 32'b110);
            1:       check("scan.an", 32'(bus.an), 32'b101);
            default: check("scan.an", 32'(bus.an), 32'b011);
         endcase
         @(negedge clk);
      end

      // FF + 01: latency, then {cout,sum}=0x100 on the display
      @(negedge clk);
      bus.a = 8'hFF; bus.b = 8'h01; bus.mode = 1'b0; bus.calc = 1'b1;
      @(negedge clk);
      bus.calc = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("lat.valid_early", 32'(bus.valid), 32'd0);
      @(negedge clk);
      check_result("add_ff_01", 8'h00, 1'b1, 1'b0);
      check_digits("add_ff_01", 4'h1, 4'h0, 4'h0);

      // Switch changes after capture leave outputs alone
      bus.a = 8'h33; bus.b = 8'h44;
      repeat (6) @(negedge clk);
      check("static.sum", 32'(bus.sum), 32'h00);

      // 7F + 01: signed overflow
      press(8'h7F, 8'h01, 1'b0);
      check_result("add_7f_01", 8'h80, 1'b0, 1'b1);
      check_digits("add_7f_01", 4'h0, 4'h8, 4'h0);

      // Subtraction cases
      press(8'h05, 8'h07, 1'b1);
      check_result("sub_05_07", 8'hFE, 1'b0, 1'b0);
      press(8'h80, 8'h01, 1'b1);
      check_result("sub_80_01", 8'h7F, 1'b1, 1'b1);
      check_digits("sub_80_01", 4'h1, 4'h7, 4'hF);

      // Held button: one capture of the first operands only
      @(negedge clk);
      bus.a = 8'h12; bus.b = 8'h03; bus.mode = 1'b0; bus.calc = 1'b1;
      repeat (8) @(negedge clk);
      bus.a = 8'h40; bus.b = 8'h05;
      repeat (12) @(negedge clk);
      check("hold.sum", 32'(bus.sum), 32'h15);
      bus.calc = 1'b0;
      repeat (4) @(negedge clk);
      check("hold.sum_after", 32'(bus.sum), 32'h15);
      press(8'h40, 8'h05, 1'b0);
      check_result("hold.second", 8'h45, 1'b0, 1'b0);

      // Reset while in CALC clears immediately and nothing is retained
      @(negedge clk);
      bus.a = 8'h7F; bus.b = 8'h01; bus.mode = 1'b0; bus.calc = 1'b1;
      @(negedge clk);
      bus.calc = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst.sum",   32'(bus.sum),   32'h00);
      check("midrst.valid", 32'(bus.valid), 32'd0);
      check("midrst.cout",  32'(bus.cout),  32'd0);
      check("midrst.an",    32'(bus.an),    32'b110);
      check("midrst.seg",   32'(bus.seg),   32'b1000000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("midrst.valid_after", 32'(bus.valid), 32'd0);
      check("midrst.sum_after",   32'(bus.sum),   32'h00);
      check("midrst.ovf_after",   32'(bus.ovf),   32'd0);

`ifdef SEG7_ADDER_BLINK_OVF_EN
      // Overflowed result: blanked for half of each 2*BLINK_DIV period
      press(8'h7F, 8'h01, 1'b0);
      check_result("blink", 8'h80, 1'b0, 1'b1);
      begin
         int blanks;
         blanks = 0;
         for (int k = 0; k < 4 * BLINK_DIV; k++) begin
            if (bus.an == 3'b111) blanks++;
            @(negedge clk);
         end
         check("blink.count", 32'(blanks), 32'(2 * BLINK_DIV));
      end
`else
      // Overflowed result never blanks the display
      press(8'h7F, 8'h01, 1'b0);
      check_result("noblink", 8'h80, 1'b0, 1'b1);
      begin
         int blanks;
         blanks = 0;
         for (int k = 0; k < 4 * BLINK_DIV; k++) begin
            if (bus.an == 3'b111) blanks++;
            @(negedge clk);
         end
         check("noblink.count", 32'(blanks), 32'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
